// File: rtl/addr_ctr.sv
// addr_ctr: {rg_a, bit_a} address sweep counter with IDLE/RUN/DONE control.
// Optional down counting is enabled by defining ADDR_CTR_DOWN_EN; without it
// the dir port is accepted but ignored and only up-count logic exists.
module addr_ctr #(
  parameter int RG_W    = 4,
  parameter int BIT_W   = 2,
  parameter int RG_NUM  = 16,
  parameter int BIT_NUM = 4
) (
  input  logic             tick,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  input  logic             once,
  input  logic             dir,
  input  logic             load,
  input  logic [RG_W-1:0]  load_rg,
  input  logic [BIT_W-1:0] load_bit,
  output logic [RG_W-1:0]  rg_a,
  output logic [BIT_W-1:0] bit_a,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam logic [RG_W-1:0]  RG_MAX  = RG_W'(RG_NUM - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(BIT_NUM - 1);
  localparam logic [RG_W-1:0]  RG_ONE  = RG_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [RG_W-1:0]  rg_q, rg_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             tc_q, tc_d;
  logic             down;
  logic             at_term;

`ifdef ADDR_CTR_DOWN_EN
  assign down = dir;
`else
  // Direction is tied to up; dir is kept on the port list for compatibility.
  logic unused_dir;
  assign unused_dir = dir;
  assign down       = 1'b0;
`endif

  assign at_term = down ? ((rg_q == '0) && (bit_q == '0))
                        : ((rg_q == RG_MAX) && (bit_q == BIT_MAX));

  // Next-state, next-address and terminal-count decode (load > start > count).
  always_comb begin
    state_d = state_q;
    rg_d    = rg_q;
    bit_d   = bit_q;
    tc_d    = 1'b0;
    if (load) begin
      rg_d    = (load_rg  > RG_MAX)  ? RG_MAX  : load_rg;
      bit_d   = (load_bit > BIT_MAX) ? BIT_MAX : load_bit;
      state_d = S_IDLE;
    end else if (start) begin
      rg_d    = down ? RG_MAX  : '0;
      bit_d   = down ? BIT_MAX : '0;
      state_d = S_RUN;
    end else if ((state_q == S_RUN) && en) begin
      if (at_term) begin
        tc_d = 1'b1;
        if (once) begin
          state_d = S_DONE;
        end else begin
          rg_d  = down ? RG_MAX  : '0;
          bit_d = down ? BIT_MAX : '0;
        end
      end else begin
`ifdef ADDR_CTR_DOWN_EN
        if (down) begin
          if (bit_q == '0) begin
            bit_d = BIT_MAX;
            rg_d  = rg_q - RG_ONE;
          end else begin
            bit_d = bit_q - BIT_ONE;
          end
        end else
`endif
        begin
          if (bit_q == BIT_MAX) begin
            bit_d = '0;
            rg_d  = rg_q + RG_ONE;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
    end
  end

  // State, address and tc registers with asynchronous clear.
  always_ff @(posedge tick or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      rg_q    <= '0;
      bit_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rg_q    <= rg_d;
      bit_q   <= bit_d;
      tc_q    <= tc_d;
    end
  end

  assign rg_a  = rg_q;
  assign bit_a = bit_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign tc    = tc_q;

endmodule

// File: doc/addr_ctr.md
ADDR_CTR -- requirements
Module: addr_ctr

Interface
REQ-001 Parameter RG_W, default 4, rg_a width in bits.
REQ-002 Parameter BIT_W, default 2, bit_a width in bits.
REQ-003 Parameter RG_NUM, default 16, register count, range 1..2**RG_W.
REQ-004 Parameter BIT_NUM, default 4, bits per register, range 1..2**BIT_W.
REQ-005 tick  in  1  clock; all state changes on rising edge.
REQ-006 clr  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  begin or restart a sweep.
REQ-008 en  in  1  count enable while running.
REQ-009 once  in  1  1 = single sweep then stop; 0 = continuous wrap.
REQ-010 dir  in  1  0 = up, 1 = down.
REQ-011 load  in  1  load address from load_rg/load_bit.
REQ-012 load_rg  in  RG_W  register address to load.
REQ-013 load_bit  in  BIT_W  bit address to load.
REQ-014 rg_a  out  RG_W  current register address, registered.
REQ-015 bit_a  out  BIT_W  current bit address, registered.
REQ-016 busy  out  1  high in RUN.
REQ-017 done  out  1  high in DONE.
REQ-018 tc  out  1  terminal-count pulse, one tick wide, registered.

Function
REQ-019 Address is the pair {rg_a, bit_a}; bit_a is least significant; one full sweep is RG_NUM*BIT_NUM addresses.
REQ-020 Up step: bit_a+1; at BIT_NUM-1 bit_a goes to 0 and rg_a+1; first address {0,0}, terminal address {RG_NUM-1,BIT_NUM-1}.
REQ-021 Down step: mirror of REQ-020; first address {RG_NUM-1,BIT_NUM-1}, terminal address {0,0}.
REQ-022 States IDLE, RUN, DONE; address holds in IDLE and DONE.
REQ-023 Priority per tick: load > start > count.
REQ-024 load in any state: address <= load values, each saturated to RG_NUM-1 / BIT_NUM-1 if out of range; state -> IDLE; tc 0.
REQ-025 start (no load) in any state: address <= first address for current dir; state -> RUN; restart allowed mid-sweep.
REQ-026 RUN, en=0: address and state hold, tc 0.
REQ-027 RUN, en=1, address not terminal: one step per tick.
REQ-028 RUN, en=1, terminal, once=0: address <= first address, stay RUN, tc=1 next cycle.
REQ-029 RUN, en=1, terminal, once=1: address holds at terminal, state -> DONE, tc=1 next cycle.
REQ-030 DONE: remains until start, load or clr.
REQ-031 dir and once are sampled every tick; changing dir in RUN continues stepping from the current address in the new direction.
REQ-032 Degenerate RG_NUM=1 or BIT_NUM=1: the corresponding field stays 0.

Reset
REQ-033 clr high forces, without a clock edge: rg_a=0, bit_a=0, state IDLE, busy=0, done=0, tc=0.
REQ-034 clr mid-sweep aborts the sweep; first tick after release behaves as IDLE.

Configuration
REQ-035 Macro ADDR_CTR_DOWN_EN defined: dir functional per REQ-021/REQ-031.
REQ-036 ADDR_CTR_DOWN_EN undefined: dir port present but ignored, counting is always up, no down-count logic is synthesised.

Verification
REQ-037 Defaults, once=1, dir=0, pulse start, en=1 -> 64 ticks {0,0}..{15,3}, tc one tick, done=1, address holds {15,3}.
REQ-038 RG_NUM=5, BIT_NUM=3, once=0 -> address wraps {4,2}->{0,0} every 15 ticks, tc each wrap, busy stays 1.
REQ-039 en toggled 1010... in RUN -> address advances only on en=1 ticks; sweep takes 128 ticks at defaults.
REQ-040 load with load_rg=15, load_bit=3 on RG_NUM=10, BIT_NUM=3 -> address {9,2}, IDLE; load and start same tick -> load wins.
REQ-041 ADDR_CTR_DOWN_EN defined, dir=1, once=1, start -> {15,3} down to {0,0}, done; undefined -> same stimulus counts up.
REQ-042 clr asserted at address {7,1} between edges -> outputs 0 immediately; start after release -> sweep from {0,0}.
